mv_cand_gen: RTL and testbench
==============================

MV_CAND_GEN -- requirements
Module: mv_cand_gen

Interface
REQ-001 SHALL have parameter MV_W, default 19, the signed MV component width in quarter-pel units.
REQ-002 SHALL have parameter HPEL_STEP, default 2, the half-pel offset in quarter-pel units.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_ASYNC_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request to generate the candidate set around the base MV.
REQ-006 SHALL have port BASE_MV_X  input  MV_W  signed horizontal base MV.
REQ-007 SHALL have port BASE_MV_Y  input  MV_W  signed vertical base MV.
REQ-008 SHALL have port STALL  input  1  downstream not ready; generation pauses.
REQ-009 SHALL have port MV_X  output  MV_W  signed horizontal candidate; feeds the MV_X holding register DATA_IN.
REQ-010 SHALL have port MV_Y  output  MV_W  signed vertical candidate; feeds the MV_Y holding register DATA_IN.
REQ-011 SHALL have port MV_VALID  output  1  candidate valid this cycle; drives holding-register WRITE_EN.
REQ-012 SHALL have port CAND_IDX  output  4  index of the current candidate.
REQ-013 SHALL have port BUSY  output  1  high in states GEN and DONE.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse after the last candidate is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, GEN, DONE.
REQ-016 SHALL, in IDLE with START=1, latch BASE_MV_X/Y, set CAND_IDX=0, and enter GEN on the next edge.
REQ-017 SHALL, while in GEN, register MV_X/MV_Y from the latched base plus the offset of CAND_IDX; the first candidate is presented the cycle after START.
REQ-018 SHALL use raster offset order (dx,dy) for idx 0-7 with s=HPEL_STEP: (-s,-s),(0,-s),(+s,-s),(-s,0),(+s,0),(-s,+s),(0,+s),(+s,+s).
REQ-019 SHALL drive MV_VALID = (state==GEN) AND NOT STALL, combinationally.
REQ-020 SHALL advance CAND_IDX only in cycles with MV_VALID=1; under STALL, MV_X, MV_Y, and CAND_IDX hold.
REQ-021 SHALL, on acceptance of the last candidate, go to DONE, pulse DONE for exactly one cycle, then return to IDLE.
REQ-022 SHALL compute each sum at MV_W+1 bits and saturate to [-2^(MV_W-1), 2^(MV_W-1)-1] (for 19 bits: [-262144, 262143]).
REQ-023 SHALL ignore START in GEN and DONE; no re-latch and no restart.
REQ-024 SHALL generate 8 candidates per START with no stall, so GEN lasts exactly 8 cycles.

Reset
REQ-025 SHALL, when RST_ASYNC_N=0 in any state including mid-GEN, immediately force state IDLE, MV_X=0, MV_Y=0, CAND_IDX=0, DONE=0, BUSY=0, MV_VALID=0, and latched base=0.
REQ-026 SHALL, after reset release, wait for a new START; an interrupted candidate set is not resumed.

Configuration
REQ-027 SHALL support macro QUARTER_PEL_REFINE_EN.
REQ-028 SHALL, when QUARTER_PEL_REFINE_EN is defined, generate idx 8-15 with the same order as REQ-018 but s=1, giving 16 candidates; the last candidate is idx 15.
REQ-029 SHALL, when QUARTER_PEL_REFINE_EN is undefined, generate only idx 0-7; the last candidate is idx 7 and CAND_IDX[3] stays 0.

Verification
REQ-030 SHALL be verified by: base (8,-4), START, no stall -> MV_VALID on 8 consecutive cycles, first (6,-6), last (10,-2), DONE one cycle after the last.
REQ-031 SHALL be verified by: base (262143,-262144) -> idx 0 = (262141,-262144) and idx 7 = (262143,-262142), saturated.
REQ-032 SHALL be verified by: STALL=1 for 3 cycles at idx 3 -> MV_VALID=0, MV_X/MV_Y/CAND_IDX held at (6,-4)/idx 3 for base (8,-4), then sequence resumes.
REQ-033 SHALL be verified by: RST_ASYNC_N pulsed low at idx 5 -> outputs 0 without waiting for a clock edge, IDLE; a new START restarts at idx 0.
REQ-034 SHALL be verified by: START re-asserted during GEN -> sequence unchanged, single DONE.
REQ-035 SHALL be verified by: QUARTER_PEL_REFINE_EN defined, base (0,0) -> 16 candidates, idx 8 = (-1,-1), idx 15 = (1,1), DONE after idx 15.

Source files
------------

// File: rtl/mv_cand_gen.sv
// Motion-vector candidate generator: emits a raster ring of offset MVs around a latched base MV.
// Optional macro QUARTER_PEL_REFINE_EN extends the set with a second ring at quarter-pel step (16 candidates).
module mv_cand_gen #(
  parameter int MV_W      = 19,
  parameter int HPEL_STEP = 2
) (
  input  logic                   CLK,
  input  logic                   RST_ASYNC_N,
  input  logic                   START,
  input  logic signed [MV_W-1:0] BASE_MV_X,
  input  logic signed [MV_W-1:0] BASE_MV_Y,
  input  logic                   STALL,
  output logic signed [MV_W-1:0] MV_X,
  output logic signed [MV_W-1:0] MV_Y,
  output logic                   MV_VALID,
  output logic [3:0]             CAND_IDX,
  output logic                   BUSY,
  output logic                   DONE
);

  // state   | meaning
  // ST_IDLE | waiting for START
  // ST_GEN  | presenting candidates, one per accepted cycle
  // ST_DONE | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DONE} state_t;

`ifdef QUARTER_PEL_REFINE_EN
  localparam logic [3:0] LAST_IDX = 4'd15;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  localparam logic signed [MV_W:0] STEP_H = (MV_W+1)'(HPEL_STEP);
  localparam logic signed [MV_W:0] STEP_Q = (MV_W+1)'(1);

  state_t                 state, state_nxt;
  logic signed [MV_W-1:0] base_x_q, base_y_q;
  logic                   last_acc;
  logic [3:0]             idx_nxt;

  function automatic logic signed [MV_W:0] step_of(input logic [3:0] idx);
    return idx[3] ? STEP_Q : STEP_H;
  endfunction

  function automatic logic signed [MV_W:0] off_x(input logic [3:0] idx);
    logic signed [MV_W:0] s;
    s = step_of(idx);
    case (idx[2:0])
      3'd0, 3'd3, 3'd5: off_x = -s;
      3'd2, 3'd4, 3'd7: off_x = s;
      default:          off_x = '0;
    endcase
  endfunction

  function automatic logic signed [MV_W:0] off_y(input logic [3:0] idx);
    logic signed [MV_W:0] s;
    s = step_of(idx);
    case (idx[2:0])
      3'd0, 3'd1, 3'd2: off_y = -s;
      3'd5, 3'd6, 3'd7: off_y = s;
      default:          off_y = '0;
    endcase
  endfunction

  // One extra bit of headroom; any carry into it means the result left the MV range.
  function automatic logic signed [MV_W-1:0] sat_add(input logic signed [MV_W-1:0] base,
                                                     input logic signed [MV_W:0]   off);
    logic signed [MV_W:0] sum;
    sum = {base[MV_W-1], base} + off;
    if (sum[MV_W] != sum[MV_W-1])
      sat_add = sum[MV_W] ? {1'b1, {(MV_W-1){1'b0}}} : {1'b0, {(MV_W-1){1'b1}}};
    else
      sat_add = sum[MV_W-1:0];
  endfunction

  always_comb begin
    MV_VALID  = (state == ST_GEN) && !STALL;
    BUSY      = (state != ST_IDLE);
    DONE      = (state == ST_DONE);
    last_acc  = MV_VALID && (CAND_IDX == LAST_IDX);
    idx_nxt   = CAND_IDX + 4'd1;
    state_nxt = state;
    case (state)
      ST_IDLE: if (START)    state_nxt = ST_GEN;
      ST_GEN:  if (last_acc) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // First candidate is built from the live base inputs so it is ready the cycle after START.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      base_x_q <= '0;
      base_y_q <= '0;
      MV_X     <= '0;
      MV_Y     <= '0;
      CAND_IDX <= '0;
    end else if (state == ST_IDLE && START) begin
      base_x_q <= BASE_MV_X;
      base_y_q <= BASE_MV_Y;
      CAND_IDX <= '0;
      MV_X     <= sat_add(BASE_MV_X, off_x(4'd0));
      MV_Y     <= sat_add(BASE_MV_Y, off_y(4'd0));
    end else if (MV_VALID && !last_acc) begin
      CAND_IDX <= idx_nxt;
      MV_X     <= sat_add(base_x_q, off_x(idx_nxt));
      MV_Y     <= sat_add(base_y_q, off_y(idx_nxt));
    end
  end

endmodule

// File: tb/tb_mv_cand_gen.sv
// Scoreboard bench for mv_cand_gen: expected candidate sets are queued at START and
// popped by an independent monitor on every MV_VALID cycle.
module tb_mv_cand_gen;

  localparam int MV_W = 19;
  localparam int HPEL = 2;
  localparam int MAXV = (1 << (MV_W-1)) - 1;
  localparam int MINV = -(1 << (MV_W-1));
`ifdef QUARTER_PEL_REFINE_EN
  localparam int NCAND = 16;
`else
  localparam int NCAND = 8;
`endif

  typedef struct {
    int x;
    int y;
    int idx;
    bit last;
  } cand_t;

  logic                   CLK = 1'b0;
  logic                   RST_ASYNC_N = 1'b0;
  logic                   START = 1'b0;
  logic signed [MV_W-1:0] BASE_MV_X = '0;
  logic signed [MV_W-1:0] BASE_MV_Y = '0;
  logic                   STALL = 1'b0;
  logic signed [MV_W-1:0] MV_X, MV_Y;
  logic                   MV_VALID, BUSY, DONE;
  logic [3:0]             CAND_IDX;

  int    checks = 0;
  int    errors = 0;
  cand_t q[$];
  bit    done_exp = 1'b0;
  bit    done_exp_nxt;
  cand_t c;

  int dxt[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int dyt[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  mv_cand_gen #(.MV_W(MV_W), .HPEL_STEP(HPEL)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START),
    .BASE_MV_X(BASE_MV_X), .BASE_MV_Y(BASE_MV_Y), .STALL(STALL),
    .MV_X(MV_X), .MV_Y(MV_Y), .MV_VALID(MV_VALID), .CAND_IDX(CAND_IDX),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic push_set(input int bx, input int by);
    cand_t e;
    for (int k = 0; k < NCAND; k++) begin
      int s;
      s      = (k >= 8) ? 1 : HPEL;
      e.x    = clamp(bx + dxt[k % 8] * s);
      e.y    = clamp(by + dyt[k % 8] * s);
      e.idx  = k;
      e.last = (k == NCAND - 1);
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops on every presented candidate; DONE must follow the last pop by one cycle.
  always @(negedge CLK) begin
    if (RST_ASYNC_N) begin
      chk("done_pulse", int'(DONE), int'(done_exp));
      done_exp_nxt = 1'b0;
      if (MV_VALID) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          c = q.pop_front();
          chk("mv_x", int'(MV_X), c.x);
          chk("mv_y", int'(MV_Y), c.y);
          chk("cand_idx", int'(CAND_IDX), c.idx);
          done_exp_nxt = c.last;
        end
      end
      done_exp = done_exp_nxt;
    end
  end

  task automatic start_set(input int bx, input int by);
    BASE_MV_X = MV_W'(bx);
    BASE_MV_Y = MV_W'(by);
    START     = 1'b1;
    push_set(bx, by);
    tick();
    START     = 1'b0;
    BASE_MV_X = MV_W'($urandom);
    BASE_MV_Y = MV_W'($urandom);
  endtask

  task automatic wait_idle(input bit rnd_stall);
    int n = 0;
    while (BUSY && n < 400) begin
      STALL = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      n++;
    end
    STALL = 1'b0;
    if (n >= 400) chk("idle_timeout", 1, 0);
    chk("leftover_cands", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mv_x"}, int'(MV_X), 0);
    chk({tag, "_mv_y"}, int'(MV_Y), 0);
    chk({tag, "_idx"}, int'(CAND_IDX), 0);
    chk({tag, "_valid"}, int'(MV_VALID), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_done"}, int'(DONE), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [MV_W-1:0] r;
    int bx, by;

    #3 chk_all_zero("reset");
    tick();
    RST_ASYNC_N = 1'b1;
    tick();

    // Unstalled run: one candidate every cycle, known first value, then DONE.
    start_set(8, -4);
    for (int i = 0; i < NCAND; i++) begin
      @(negedge CLK);
      chk("consec_valid", int'(MV_VALID), 1);
      if (i == 0) begin
        chk("first_x", int'(MV_X), 6);
        chk("first_y", int'(MV_Y), -6);
      end
      if (i == 7) begin
        chk("idx7_x", int'(MV_X), 10);
        chk("idx7_y", int'(MV_Y), -2);
      end
    end
    @(negedge CLK);
    chk("done_after_last", int'(DONE), 1);
    @(negedge CLK);
    chk("idle_after_done", int'(BUSY), 0);
    tick();

    // Saturation at both range ends.
    start_set(MAXV, MINV);
    wait_idle(1'b0);

    // Stall for three cycles while idx 3 is presented.
    start_set(8, -4);
    repeat (3) tick();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_valid", int'(MV_VALID), 0);
      chk("stall_x", int'(MV_X), 6);
      chk("stall_y", int'(MV_Y), -4);
      chk("stall_idx", int'(CAND_IDX), 3);
      tick();
    end
    STALL = 1'b0;
    wait_idle(1'b0);

    // START re-asserted mid-set with a different base must be ignored.
    start_set(100, 200);
    repeat (3) tick();
    BASE_MV_X = MV_W'(-5000);
    BASE_MV_Y = MV_W'(7777);
    START = 1'b1;
    repeat (2) tick();
    START = 1'b0;
    wait_idle(1'b0);

    // Asynchronous reset while idx 5 is presented.
    start_set(-1234, 4321);
    repeat (5) tick();
    @(negedge CLK);
    chk("pre_reset_idx", int'(CAND_IDX), 5);
    #2 RST_ASYNC_N = 1'b0;
    #1 chk_all_zero("async_rst");
    q.delete();
    done_exp = 1'b0;
    tick();
    tick();
    chk_all_zero("held_rst");
    RST_ASYNC_N = 1'b1;
    repeat (3) tick();
    chk("no_resume_busy", int'(BUSY), 0);
    start_set(0, 0);
    wait_idle(1'b0);

    // Randomized bases (some pinned near the range ends) with random stalls.
    for (int n = 0; n < 24; n++) begin
      r  = MV_W'($urandom);
      bx = r;
      r  = MV_W'($urandom);
      by = r;
      case (n % 4)
        1: bx = MAXV - int'($urandom_range(0, 3));
        2: by = MINV + int'($urandom_range(0, 3));
        default: ;
      endcase
      start_set(bx, by);
      wait_idle(1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
